// File: rtl/lpb_pkg.sv
// Shared constants, types and helpers for the LPB kernel arbiter.
package lpb_pkg;

   localparam int DATA_W    = 64;
   localparam int N_FIELDS  = 8;
   localparam int BUNDLE_W  = DATA_W * N_FIELDS;
   localparam int N_REQ_DEF = 4;
   localparam int TAG_W     = (N_REQ_DEF > 1) ? $clog2(N_REQ_DEF) : 1;

   typedef logic [BUNDLE_W-1:0] lpb_bundle_t;
   typedef logic [TAG_W-1:0]    lpb_tag_t;

   // Next index in a ring of n entries.
   function automatic int lpb_wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/lpb_tag_fifo.sv
// Show-ahead tag FIFO recording which requester owns each in-flight bundle.
module lpb_tag_fifo #(
   parameter int  DEPTH = 8,
   parameter int  WIDTH = lpb_pkg::TAG_W,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);
   import lpb_pkg::*;

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Full is judged on the pre-pop occupancy, so a full FIFO never takes a push.
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointers and occupancy; depth is a power of two so pointers wrap naturally.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Tag storage carries no reset; only entries between the pointers are meaningful.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/lpb_arbiter.sv
// Round-robin arbiter sharing one LPB kernel between N_REQ requesters,
// issuing start tokens per accepted bundle and routing results back in order.
module lpb_arbiter #(
   parameter int  N_REQ    = 4,
   parameter int  MAX_OUT  = 8,
   parameter int  DATA_W   = lpb_pkg::DATA_W,
   parameter int  N_FIELDS = lpb_pkg::N_FIELDS,
   localparam int BUN_W    = DATA_W * N_FIELDS,
   localparam int CNT_W    = $clog2(MAX_OUT) + 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*BUN_W-1:0]   req_data,
   output logic                     k_in0_valid,
   input  logic                     k_in0_ready,
   output logic [BUN_W-1:0]         k_in0_data,
   output logic                     k_inCtrl_valid,
   input  logic                     k_inCtrl_ready,
   input  logic                     k_out0_valid,
   output logic                     k_out0_ready,
   input  logic [BUN_W-1:0]         k_out0_data,
   input  logic                     k_outCtrl_valid,
   output logic                     k_outCtrl_ready,
   output logic [N_REQ-1:0]         rsp_valid,
   input  logic [N_REQ-1:0]         rsp_ready,
   output logic [BUN_W-1:0]         rsp_data,
   output logic [CNT_W-1:0]         outstanding,
   output logic [31:0]              done_cnt,
   output logic                     err_orphan
);
   import lpb_pkg::*;

   localparam int               IDX_W   = $clog2(N_REQ);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] head;
   logic [CNT_W-1:0] pend_ctrl;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             can_issue;
   logic             accept;
   logic             ctrl_hs;
   logic             pop;

   // First requester with valid set, scanning upward from start and wrapping.
   // With nobody requesting the pointer itself is returned so the mux select stays defined.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                                input logic [IDX_W-1:0] start);
      logic [IDX_W-1:0] pick;
      int               idx;
      pick = start;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (valid[idx]) pick = IDX_W'(idx);
      end
      return pick;
   endfunction

   assign grant       = rr_pick(req_valid, rr_ptr);
   assign can_issue   = !fifo_full && (fifo_count < MAX_CNT) && (pend_ctrl < MAX_CNT);
   assign k_in0_valid = (|req_valid) && can_issue;
   assign k_in0_data  = req_data[int'(grant)*BUN_W +: BUN_W];
   assign accept      = k_in0_valid && k_in0_ready;

   // Accept strobe goes only to the granted requester.
   always_comb begin
      req_ready = '0;
      if (k_in0_ready && can_issue) req_ready[grant] = 1'b1;
   end

   assign k_inCtrl_valid  = (pend_ctrl != '0);
   assign ctrl_hs         = k_inCtrl_valid && k_inCtrl_ready;
   assign k_outCtrl_ready = 1'b1;

   // Results go to the oldest owner; with no owner on record the kernel is held off.
   assign rsp_data     = k_out0_data;
   assign k_out0_ready = rsp_ready[head] && !fifo_empty;
   assign pop          = k_out0_valid && k_out0_ready;
   assign outstanding  = fifo_count;

   // Result valid steered to the tag at the FIFO head.
   always_comb begin
      rsp_valid = '0;
      if (k_out0_valid && !fifo_empty) rsp_valid[head] = 1'b1;
   end

   lpb_tag_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (IDX_W)
   ) u_tag_fifo (
      .clock (clock),
      .reset (reset),
      .push  (accept),
      .pop   (pop),
      .din   (grant),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Round-robin pointer advances past the winner; start tokens owed track accepts.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_ptr    <= '0;
         pend_ctrl <= '0;
      end else begin
         if (accept) rr_ptr <= IDX_W'(lpb_wrap_inc(int'(grant), N_REQ));
         case ({accept, ctrl_hs})
            2'b10:   pend_ctrl <= pend_ctrl + CNT_W'(1);
            2'b01:   pend_ctrl <= pend_ctrl - CNT_W'(1);
            default: pend_ctrl <= pend_ctrl;
         endcase
      end
   end

   // Done-token counter and sticky orphan-result flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         done_cnt   <= '0;
         err_orphan <= 1'b0;
      end else begin
         if (k_outCtrl_valid) done_cnt <= done_cnt + 32'd1;
         if (k_out0_valid && fifo_empty) err_orphan <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lpb_arbiter.sv
// Self-checking bench for lpb_arbiter: directed scenarios with literal
// expectations plus randomized traffic against a queue-based reference model.
module tb_lpb_arbiter;

   localparam int N_REQ   = 4;
   localparam int MAX_OUT = 8;
   localparam int BW      = 64 * 8;
   localparam int CW      = $clog2(MAX_OUT) + 1;

   logic                   clock = 1'b0;
   logic                   reset;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*BW-1:0]    req_data;
   logic                   k_in0_valid;
   logic                   k_in0_ready;
   logic [BW-1:0]          k_in0_data;
   logic                   k_inCtrl_valid;
   logic                   k_inCtrl_ready;
   logic                   k_out0_valid;
   logic                   k_out0_ready;
   logic [BW-1:0]          k_out0_data;
   logic                   k_outCtrl_valid;
   logic                   k_outCtrl_ready;
   logic [N_REQ-1:0]       rsp_valid;
   logic [N_REQ-1:0]       rsp_ready;
   logic [BW-1:0]          rsp_data;
   logic [CW-1:0]          outstanding;
   logic [31:0]            done_cnt;
   logic                   err_orphan;

   int total = 0;
   int bad   = 0;
   int ictr  = 0;

   // Reference model: tag queue of owners, start tokens owed, pointer, counters.
   int          m_q[$];
   int          m_rr;
   int          m_pend;
   logic [31:0] m_done;
   bit          m_orph;
   bit          chk_en = 1'b0;

   always #5 clock = ~clock;

   lpb_arbiter #(.N_REQ(N_REQ), .MAX_OUT(MAX_OUT)) dut (
      .clock           (clock),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_data        (req_data),
      .k_in0_valid     (k_in0_valid),
      .k_in0_ready     (k_in0_ready),
      .k_in0_data      (k_in0_data),
      .k_inCtrl_valid  (k_inCtrl_valid),
      .k_inCtrl_ready  (k_inCtrl_ready),
      .k_out0_valid    (k_out0_valid),
      .k_out0_ready    (k_out0_ready),
      .k_out0_data     (k_out0_data),
      .k_outCtrl_valid (k_outCtrl_valid),
      .k_outCtrl_ready (k_outCtrl_ready),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_data        (rsp_data),
      .outstanding     (outstanding),
      .done_cnt        (done_cnt),
      .err_orphan      (err_orphan)
   );

   task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int m_grant();
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (m_rr + k) % N_REQ;
         if (req_valid[idx]) return idx;
      end
      return m_rr;
   endfunction

   // Expected outputs for the current inputs and model state.
   task automatic model_check();
      int               n;
      int               g;
      int               h;
      bit               can;
      logic [N_REQ-1:0] e_rdy;
      logic [N_REQ-1:0] e_rsp;
      bit               e_kr;
      n   = m_q.size();
      g   = m_grant();
      can = (n < MAX_OUT) && (m_pend < MAX_OUT);
      e_rdy = (k_in0_ready && can) ? (N_REQ'(1) << g) : '0;
      e_rsp = '0;
      e_kr  = 1'b0;
      if (n > 0) begin
         h = m_q[0];
         if (k_out0_valid) e_rsp = N_REQ'(1) << h;
         e_kr = rsp_ready[h];
      end
      chk("m k_in0_valid",     BW'(k_in0_valid),     BW'((|req_valid) && can));
      chk("m k_in0_data",      k_in0_data,           req_data[g*BW +: BW]);
      chk("m req_ready",       BW'(req_ready),       BW'(e_rdy));
      chk("m k_inCtrl_valid",  BW'(k_inCtrl_valid),  BW'(m_pend != 0));
      chk("m rsp_valid",       BW'(rsp_valid),       BW'(e_rsp));
      chk("m k_out0_ready",    BW'(k_out0_ready),    BW'(e_kr));
      chk("m rsp_data",        rsp_data,             k_out0_data);
      chk("m outstanding",     BW'(outstanding),     BW'(n));
      chk("m done_cnt",        BW'(done_cnt),        BW'(m_done));
      chk("m err_orphan",      BW'(err_orphan),      BW'(m_orph));
      chk("m k_outCtrl_ready", BW'(k_outCtrl_ready), BW'(1));
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      int g;
      int n;
      bit can;
      bit acc;
      bit ic;
      bit pop;
      if (reset) begin
         m_q.delete();
         m_rr   = 0;
         m_pend = 0;
         m_done = '0;
         m_orph = 1'b0;
         chk_en = 1'b1;
         return;
      end
      if (!chk_en) return;
      n   = m_q.size();
      g   = m_grant();
      can = (n < MAX_OUT) && (m_pend < MAX_OUT);
      acc = (|req_valid) && can && k_in0_ready;
      ic  = (m_pend != 0) && k_inCtrl_ready;
      pop = k_out0_valid && (n > 0) && rsp_ready[m_q[0]];
      if (k_out0_valid && n == 0) m_orph = 1'b1;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
         m_q.push_back(g);
         m_rr = (g + 1) % N_REQ;
      end
      m_pend = m_pend + int'(acc) - int'(ic);
      if (k_outCtrl_valid) m_done = m_done + 32'd1;
   endtask

   // One clock: model compare mid-cycle, model update at the edge, return just after.
   task automatic tick();
      @(negedge clock);
      #1;
      if (chk_en) model_check();
      if (k_inCtrl_valid && k_inCtrl_ready) ictr++;
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic idle();
      req_valid       = '0;
      k_in0_ready     = 1'b0;
      k_inCtrl_ready  = 1'b1;
      k_out0_valid    = 1'b0;
      rsp_ready       = '1;
      k_outCtrl_valid = 1'b0;
   endtask

   task automatic rnd_data();
      for (int i = 0; i < N_REQ * BW / 32; i++) req_data[i*32 +: 32] = $urandom;
      for (int i = 0; i < BW / 32; i++) k_out0_data[i*32 +: 32] = $urandom;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int ic0;
      int guard;
      reset       = 1'b1;
      req_data    = '0;
      k_out0_data = '0;
      idle();
      tick();
      tick();
      reset = 1'b0;

      // Reset state
      #2;
      chk("rst outstanding",     BW'(outstanding),     BW'(0));
      chk("rst done_cnt",        BW'(done_cnt),        BW'(0));
      chk("rst err_orphan",      BW'(err_orphan),      BW'(0));
      chk("rst k_in0_valid",     BW'(k_in0_valid),     BW'(0));
      chk("rst k_inCtrl_valid",  BW'(k_inCtrl_valid),  BW'(0));
      chk("rst req_ready",       BW'(req_ready),       BW'(0));
      chk("rst rsp_valid",       BW'(rsp_valid),       BW'(0));
      chk("rst k_out0_ready",    BW'(k_out0_ready),    BW'(0));
      chk("rst k_outCtrl_ready", BW'(k_outCtrl_ready), BW'(1));
      tick();

      // Single requester, three bundles, kernel echoes after a gap
      ic0 = ictr;
      req_valid   = 4'b0001;
      k_in0_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rnd_data();
         #2;
         if (i == 0) chk("s1 inCtrl before accept", BW'(k_inCtrl_valid), BW'(0));
         if (i == 1) chk("s1 inCtrl after accept",  BW'(k_inCtrl_valid), BW'(1));
         chk("s1 grant", BW'(req_ready), BW'(4'b0001));
         tick();
      end
      req_valid = '0;
      tick();
      for (int i = 0; i < 3; i++) begin
         rnd_data();
         k_out0_valid    = 1'b1;
         k_outCtrl_valid = 1'b1;
         #2;
         chk("s1 rsp_valid",    BW'(rsp_valid),    BW'(4'b0001));
         chk("s1 k_out0_ready", BW'(k_out0_ready), BW'(1));
         tick();
      end
      k_out0_valid    = 1'b0;
      k_outCtrl_valid = 1'b0;
      #2;
      chk("s1 done_cnt",     BW'(done_cnt),    BW'(3));
      chk("s1 outstanding",  BW'(outstanding), BW'(0));
      chk("s1 inCtrl count", BW'(ictr - ic0),  BW'(3));
      tick();

      // Fairness over eight accepts, which also fills the tag FIFO
      do_reset();
      rnd_data();
      req_valid   = '1;
      k_in0_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #2;
         chk("fair grant", BW'(req_ready), BW'(4'b0001 << (i % 4)));
         tick();
      end
      #2;
      chk("full k_in0_valid", BW'(k_in0_valid), BW'(0));
      chk("full outstanding", BW'(outstanding), BW'(8));
      k_out0_valid = 1'b1;
      #1;
      chk("full pop blocks issue", BW'(k_in0_valid), BW'(0));
      chk("full pop route",        BW'(rsp_valid),   BW'(4'b0001));
      tick();
      #2;
      chk("reissue k_in0_valid", BW'(k_in0_valid), BW'(1));
      chk("reissue grant",       BW'(req_ready),   BW'(4'b0001));
      chk("reissue route",       BW'(rsp_valid),   BW'(4'b0010));
      tick();
      #2;
      chk("acc+pop outstanding", BW'(outstanding), BW'(7));
      k_out0_valid = 1'b0;
      #1;
      chk("refill grant", BW'(req_ready), BW'(4'b0010));
      tick();
      #2;
      chk("refill outstanding", BW'(outstanding), BW'(8));
      chk("refill k_in0_valid", BW'(k_in0_valid), BW'(0));
      req_valid    = '0;
      k_out0_valid = 1'b1;
      guard = 0;
      while (outstanding != '0 && guard < 20) begin
         tick();
         guard++;
      end
      k_out0_valid = 1'b0;
      chk("drain outstanding", BW'(outstanding), BW'(0));
      tick();

      // Mixed return routing 2,0,3 with a stall on requester 0
      do_reset();
      rnd_data();
      k_in0_ready = 1'b1;
      req_valid = 4'b0100; #2; chk("mix grant 2", BW'(req_ready), BW'(4'b0100)); tick();
      req_valid = 4'b0001; #2; chk("mix grant 0", BW'(req_ready), BW'(4'b0001)); tick();
      req_valid = 4'b1000; #2; chk("mix grant 3", BW'(req_ready), BW'(4'b1000)); tick();
      req_valid    = '0;
      k_out0_valid = 1'b1;
      #2;
      chk("mix route 2", BW'(rsp_valid), BW'(4'b0100));
      tick();
      rsp_ready = 4'b1110;
      for (int i = 0; i < 2; i++) begin
         #2;
         chk("mix stall rsp_valid", BW'(rsp_valid),    BW'(4'b0001));
         chk("mix stall ready",     BW'(k_out0_ready), BW'(0));
         chk("mix stall outst",     BW'(outstanding),  BW'(2));
         tick();
      end
      rsp_ready = '1;
      #2;
      chk("mix route 0",       BW'(rsp_valid),    BW'(4'b0001));
      chk("mix release ready", BW'(k_out0_ready), BW'(1));
      tick();
      #2;
      chk("mix route 3", BW'(rsp_valid), BW'(4'b1000));
      tick();
      k_out0_valid = 1'b0;

      // Orphan result with nothing outstanding
      k_out0_valid = 1'b1;
      #2;
      chk("orph k_out0_ready", BW'(k_out0_ready), BW'(0));
      chk("orph rsp_valid",    BW'(rsp_valid),    BW'(0));
      chk("orph not yet",      BW'(err_orphan),   BW'(0));
      tick();
      k_out0_valid = 1'b0;
      #2;
      chk("orph set", BW'(err_orphan), BW'(1));
      tick();
      tick();
      #2;
      chk("orph sticky", BW'(err_orphan), BW'(1));
      do_reset();
      #2;
      chk("orph cleared", BW'(err_orphan), BW'(0));

      // Reset mid-flight with start tokens held off
      k_outCtrl_valid = 1'b1;
      tick();
      tick();
      k_outCtrl_valid = 1'b0;
      k_inCtrl_ready  = 1'b0;
      k_in0_ready     = 1'b1;
      req_valid       = 4'b0001;
      tick();
      tick();
      tick();
      req_valid = '0;
      #2;
      chk("mid outstanding", BW'(outstanding),    BW'(3));
      chk("mid inCtrl",      BW'(k_inCtrl_valid), BW'(1));
      chk("mid done_cnt",    BW'(done_cnt),       BW'(2));
      do_reset();
      #2;
      chk("mid rst outstanding", BW'(outstanding),    BW'(0));
      chk("mid rst inCtrl",      BW'(k_inCtrl_valid), BW'(0));
      chk("mid rst done_cnt",    BW'(done_cnt),       BW'(0));
      req_valid   = '1;
      k_in0_ready = 1'b1;
      #1;
      chk("mid rst rr_ptr", BW'(req_ready), BW'(4'b0001));
      tick();

      // Randomized traffic, occasional resets, model checked every cycle
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         rnd_data();
         reset           = ($urandom_range(0, 299) == 0);
         req_valid       = N_REQ'($urandom);
         k_in0_ready     = ($urandom_range(0, 3) != 0);
         k_inCtrl_ready  = ($urandom_range(0, 2) != 0);
         k_out0_valid    = ($urandom_range(0, 2) != 0);
         rsp_ready       = N_REQ'($urandom) | N_REQ'($urandom);
         k_outCtrl_valid = ($urandom_range(0, 3) == 0);
         tick();
      end
      reset = 1'b0;
      idle();
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
